// File: rtl/io_port_pkg.sv
// Shared constants for the io_port_bank GPIO block: register offsets within a
// channel window and the default parameter values.
package io_port_pkg;

    // Register offsets within each 4-byte channel window
    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_DDR   = 2'd1;
    localparam logic [1:0] REG_IFLAG = 2'd2;
    localparam logic [1:0] REG_IMASK = 2'd3;

    // Default parameter values
    localparam int unsigned DEF_CHANNELS    = 2;
    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_ADDR_W      = 5;

endpackage

// File: rtl/io_port_sync.sv
// WIDTH-bit multi-stage input synchroniser for one GPIO channel. It also
// provides a registered copy of the synchronised value from the previous clk,
// which is used for edge detection.
module io_port_sync #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] synced,
    output logic [WIDTH-1:0] prev
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stages;

    // Shift the asynchronous pins through the stage chain; keep last value for edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= '0;
            prev   <= '0;
        end else begin
            stages[0] <= async_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                stages[i] <= stages[i-1];
            end
            prev <= stages[SYNC_STAGES-1];
        end
    end

    assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of CHANNELS general-purpose I/O ports, WIDTH bits each,
// for the 65C02 system bus. Each channel has DATA, DDR, IFLAG and IMASK
// registers at offsets 0..3 of a 4-byte window.
// Optional feature macro: IO_PORT_IRQ_EN builds the rising-edge interrupt
// flags, masks, arm counter and irq; without it IFLAG/IMASK read 0 and irq is 0.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int unsigned CHANNELS    = DEF_CHANNELS,
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         addr,
    input  logic                      sel,
    input  logic                      read,
    input  logic                      write,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic [CHANNELS*WIDTH-1:0] pin_in,
    output logic [CHANNELS*WIDTH-1:0] pin_out,
    output logic [CHANNELS*WIDTH-1:0] pin_oe,
    output logic                      irq
);

    localparam int unsigned N    = CHANNELS * WIDTH;
    localparam int unsigned CH_W = ADDR_W - 2;

    logic [CH_W-1:0]     ch_idx;
    logic [1:0]          reg_idx;
    logic [CHANNELS-1:0] ch_hit;
    logic                wr_act;
    logic                wr_prev;
    logic                commit;
    logic [N-1:0]        out_q;
    logic [N-1:0]        ddr_q;
    logic [N-1:0]        synced;
    logic [N-1:0]        prev;
    logic [7:0]          rd_val;
    logic                unused_data;

    assign ch_idx      = addr[ADDR_W-1:2];
    assign reg_idx     = addr[1:0];
    assign unused_data = ^data_in;

    // Decode the channel; indices at or above CHANNELS hit nothing
    always_comb begin
        ch_hit = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            ch_hit[c] = (32'(ch_idx) == 32'(c));
        end
    end

    // Remember the previous strobe level so a held write commits only once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_prev <= 1'b0;
        end else begin
            wr_prev <= wr_act;
        end
    end

    assign wr_act = sel & write;
    assign commit = wr_act & ~wr_prev;

    // Output latches and direction registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            ddr_q <= '0;
        end else begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (commit && ch_hit[c] && reg_idx == REG_DATA) begin
                    out_q[c*WIDTH +: WIDTH] <= data_in[WIDTH-1:0];
                end
                if (commit && ch_hit[c] && reg_idx == REG_DDR) begin
                    ddr_q[c*WIDTH +: WIDTH] <= data_in[WIDTH-1:0];
                end
            end
        end
    end

    assign pin_out = out_q;
    assign pin_oe  = ddr_q;

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_sync
        io_port_sync #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .async_in (pin_in[c*WIDTH +: WIDTH]),
            .synced   (synced[c*WIDTH +: WIDTH]),
            .prev     (prev[c*WIDTH +: WIDTH])
        );
    end

`ifdef IO_PORT_IRQ_EN
    localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [N-1:0] flag_q;
    logic [N-1:0] mask_q;
    logic [N-1:0] ddr_prev;
    logic [N-1:0] flag_set;
    logic [N-1:0] flag_clr;
    logic [2:0]   arm_cnt;
    logic         armed;
    logic         irq_q;

    // Count clocks after reset release until the synchroniser has filled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 3'd1;
        end
    end

    assign armed = (arm_cnt == ARM_MAX);

    // Rising edge on an input-direction bit that was also input last clk
    assign flag_set = {N{armed}} & synced & ~prev & ~ddr_q & ~ddr_prev;

    // Write-1-to-clear pattern for the addressed IFLAG register
    always_comb begin
        flag_clr = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (commit && ch_hit[c] && reg_idx == REG_IFLAG) begin
                flag_clr[c*WIDTH +: WIDTH] = data_in[WIDTH-1:0];
            end
        end
    end

    // Flags (set wins over clear), masks, direction history and registered irq
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q   <= '0;
            mask_q   <= '0;
            ddr_prev <= '0;
            irq_q    <= 1'b0;
        end else begin
            flag_q   <= (flag_q & ~flag_clr) | flag_set;
            ddr_prev <= ddr_q;
            irq_q    <= |(flag_q & mask_q);
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (commit && ch_hit[c] && reg_idx == REG_IMASK) begin
                    mask_q[c*WIDTH +: WIDTH] <= data_in[WIDTH-1:0];
                end
            end
        end
    end

    assign irq = irq_q;
`else
    logic unused_prev;

    assign unused_prev = ^prev;
    assign irq         = 1'b0;
`endif

    // Read mux: DATA mixes latch and synchronised input per direction bit
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (ch_hit[c]) begin
                unique case (reg_idx)
                    REG_DATA: rd_val[WIDTH-1:0] =
                        (out_q[c*WIDTH +: WIDTH] & ddr_q[c*WIDTH +: WIDTH]) |
                        (synced[c*WIDTH +: WIDTH] & ~ddr_q[c*WIDTH +: WIDTH]);
                    REG_DDR:  rd_val[WIDTH-1:0] = ddr_q[c*WIDTH +: WIDTH];
`ifdef IO_PORT_IRQ_EN
                    REG_IFLAG: rd_val[WIDTH-1:0] = flag_q[c*WIDTH +: WIDTH];
                    REG_IMASK: rd_val[WIDTH-1:0] = mask_q[c*WIDTH +: WIDTH];
`else
                    REG_IFLAG: rd_val = '0;
                    REG_IMASK: rd_val = '0;
`endif
                    default:  rd_val = '0;
                endcase
            end
        end
    end

    // Registered read data, reloaded every clk while the read strobe is active
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= 8'h00;
        end else if (sel && read) begin
            data_out <= rd_val;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank with default parameters
// (2 channels x 8 bits, 2 synchroniser stages, 5-bit address).
module tb_io_port_bank;
    import io_port_pkg::*;

    localparam int unsigned CHANNELS    = 2;
    localparam int unsigned WIDTH       = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned ADDR_W      = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  addr;
    logic        sel;
    logic        read;
    logic        write;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [15:0] pin_in;
    logic [15:0] pin_out;
    logic [15:0] pin_oe;
    logic        irq;
    logic [7:0]  rv;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    io_port_bank #(
        .CHANNELS    (CHANNELS),
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .sel      (sel),
        .read     (read),
        .write    (write),
        .data_in  (data_in),
        .data_out (data_out),
        .pin_in   (pin_in),
        .pin_out  (pin_out),
        .pin_oe   (pin_oe),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ra(input int ch, input logic [1:0] r);
        return 5'(ch * 4) | {3'b000, r};
    endfunction

    // One write strobe; returns at the negedge after the commit edge
    task automatic wr(input int ch, input logic [1:0] r, input logic [7:0] d);
        @(negedge clk);
        addr = ra(ch, r); data_in = d; sel = 1'b1; write = 1'b1;
        @(negedge clk);
        sel = 1'b0; write = 1'b0;
    endtask

    // One-clk read strobe; samples data_out at the following negedge
    task automatic rd(input int ch, input logic [1:0] r, output logic [7:0] d);
        @(negedge clk);
        addr = ra(ch, r); sel = 1'b1; read = 1'b1;
        @(negedge clk);
        d = data_out; sel = 1'b0; read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; data_in = '0; pin_in = '0;
        repeat (3) @(negedge clk);
        check("reset_pin_out", pin_out, 16'h0000);
        check("reset_pin_oe", pin_oe, 16'h0000);
        check("reset_data_out", {8'h00, data_out}, 16'h0000);
        check("reset_irq", {15'd0, irq}, 16'h0000);
        reset = 1'b0;

        // DATA/DDR writes on channel 0
        wr(0, REG_DDR, 8'hFF);
        check("ddr0_oe", pin_oe, 16'h00FF);
        wr(0, REG_DATA, 8'hA5);
        check("data0_out", pin_out, 16'h00A5);
        rd(0, REG_DATA, rv);
        check("data0_read", {8'h00, rv}, 16'h00A5);
        rd(0, REG_DDR, rv);
        check("ddr0_read", {8'h00, rv}, 16'h00FF);

        // Held strobe: only the first clk commits
        @(negedge clk);
        addr = ra(0, REG_DATA); data_in = 8'h11; sel = 1'b1; write = 1'b1;
        repeat (4) @(negedge clk);
        check("held_first", pin_out, 16'h0011);
        data_in = 8'h22;
        repeat (4) @(negedge clk);
        check("held_single", pin_out, 16'h0011);
        sel = 1'b0; write = 1'b0;
        wr(0, REG_DATA, 8'h5A);
        check("new_strobe", pin_out, 16'h005A);

        // Mixed direction on channel 1: low nibble output, high nibble input
        wr(1, REG_DDR, 8'h0F);
        wr(1, REG_DATA, 8'h05);
        check("ch1_out", pin_out, 16'h055A);
        check("ch1_oe", pin_oe, 16'h0FFF);
        @(negedge clk);
        pin_in[15:8] = 8'hC0; addr = ra(1, REG_DATA); sel = 1'b1; read = 1'b1;
        @(negedge clk);
        check("mixed_e1", {8'h00, data_out}, 16'h0005);
        @(negedge clk);
        check("mixed_e2", {8'h00, data_out}, 16'h0005);
        @(negedge clk);
        check("mixed_e3", {8'h00, data_out}, 16'h00C5);
        // Input bits under output-direction positions must not leak into DATA
        pin_in[15:8] = 8'h3A;
        repeat (3) @(negedge clk);
        check("mixed_mask", {8'h00, data_out}, 16'h0035);
        sel = 1'b0; read = 1'b0;

        // Channel index beyond CHANNELS
        rd(2, REG_DATA, rv);
        check("oob_read_data", {8'h00, rv}, 16'h0000);
        wr(1, REG_DATA, 8'h05);
        rd(1, REG_DDR, rv);
        rd(7, REG_DDR, rv);
        check("oob_read_ddr", {8'h00, rv}, 16'h0000);
        wr(2, REG_DATA, 8'hFF);
        wr(3, REG_DDR, 8'hFF);
        check("oob_write_out", pin_out, 16'h055A);
        check("oob_write_oe", pin_oe, 16'h0FFF);

        wr(0, REG_DDR, 8'h00);
        check("ddr0_clear", pin_oe, 16'h0F00);
`ifdef IO_PORT_IRQ_EN
        wr(0, REG_IMASK, 8'h01);
        rd(0, REG_IMASK, rv);
        check("imask0_read", {8'h00, rv}, 16'h0001);
        check("irq_idle", {15'd0, irq}, 16'h0000);
        // Rising edge: flag at edge 3, irq at edge 4
        @(negedge clk);
        pin_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("irq_before", {15'd0, irq}, 16'h0000);
        @(negedge clk);
        check("irq_set", {15'd0, irq}, 16'h0001);
        rd(0, REG_IFLAG, rv);
        check("iflag0_set", {8'h00, rv}, 16'h0001);
        // Clear with pin still high: irq falls one clk after the clear commit
        wr(0, REG_IFLAG, 8'h01);
        check("irq_clear_lag", {15'd0, irq}, 16'h0001);
        @(negedge clk);
        check("irq_cleared", {15'd0, irq}, 16'h0000);
        repeat (6) @(negedge clk);
        check("irq_no_reset", {15'd0, irq}, 16'h0000);
        rd(0, REG_IFLAG, rv);
        check("iflag0_clear", {8'h00, rv}, 16'h0000);
        // Set and clear landing on the same edge: set wins
        pin_in[0] = 1'b0;
        repeat (5) @(negedge clk);
        pin_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        addr = ra(0, REG_IFLAG); data_in = 8'h01; sel = 1'b1; write = 1'b1;
        @(negedge clk);
        sel = 1'b0; write = 1'b0;
        rd(0, REG_IFLAG, rv);
        check("set_wins_flag", {8'h00, rv}, 16'h0001);
        check("set_wins_irq", {15'd0, irq}, 16'h0001);
`else
        wr(0, REG_IMASK, 8'hFF);
        rd(0, REG_IMASK, rv);
        check("off_imask_read", {8'h00, rv}, 16'h0000);
        @(negedge clk);
        pin_in[7:0] = 8'hFF;
        repeat (6) @(negedge clk);
        rd(0, REG_IFLAG, rv);
        check("off_iflag_read", {8'h00, rv}, 16'h0000);
        check("off_irq", {15'd0, irq}, 16'h0000);
        rd(0, REG_DATA, rv);
        check("off_data_input", {8'h00, rv}, 16'h00FF);
`endif

        // Reset during a held write strobe, with pin_in[0] high throughout
        pin_in = 16'h0001;
        @(negedge clk);
        addr = ra(0, REG_DATA); data_in = 8'h3C; sel = 1'b1; write = 1'b1;
        @(negedge clk);
        check("pre_reset_out", pin_out[7:0], 16'h003C);
        #2 reset = 1'b1;
        #1;
        check("async_reset_out", pin_out, 16'h0000);
        check("async_reset_oe", pin_oe, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("release_commit", pin_out, 16'h003C);
        sel = 1'b0; write = 1'b0;
        wr(0, REG_IMASK, 8'h01);
        repeat (8) @(negedge clk);
        check("arm_irq", {15'd0, irq}, 16'h0000);
        rd(0, REG_IFLAG, rv);
        check("arm_iflag", {8'h00, rv}, 16'h0000);
        rd(0, REG_DATA, rv);
        check("post_reset_data", {8'h00, rv}, 16'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
